// File: rtl/modport_apb_pkg.sv
// Shared register map for the modport APB slave.
// Holds the register offsets, reset values, CTRL write mask and the decoded register select type.
package modport_apb_pkg;

  localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG1_ADDR = 32'h0000_0004;
  localparam logic [31:0] REG2_ADDR = 32'h0000_0008;
  localparam logic [31:0] REG3_ADDR = 32'h0000_000C;
  localparam logic [31:0] ID_ADDR   = 32'h0000_0010;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0000;
  localparam logic [31:0] REG1_RESET = 32'h0000_0000;
  localparam logic [31:0] REG2_RESET = 32'h1234_5678;
  localparam logic [31:0] REG3_RESET = 32'hFFFF_0000;

  // Only CTRL[7:0] is implemented; upper bits are dropped on write and read back as 0.
  localparam logic [31:0] CTRL_WMASK = 32'h0000_00FF;

  localparam logic [31:0] ID_VALUE = 32'h0A9B_0001;

  typedef enum logic [2:0] {
    SelCtrl,
    SelReg1,
    SelReg2,
    SelReg3,
    SelId,
    SelNone
  } reg_sel_e;

endpackage

// File: rtl/modport_apb_regfile.sv
// Register storage for the APB slave: address decode, write enables and combinational read mux.
// Writes and the synchronous reset both land on the posedge of pclk; reset wins.
module modport_apb_regfile
  import modport_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl = ADDR_WIDTH'(CTRL_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrReg1 = ADDR_WIDTH'(REG1_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrReg2 = ADDR_WIDTH'(REG2_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrReg3 = ADDR_WIDTH'(REG3_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrId   = ADDR_WIDTH'(ID_ADDR);

  localparam logic [DATA_WIDTH-1:0] CtrlMask  = DATA_WIDTH'(CTRL_WMASK);
  localparam logic [DATA_WIDTH-1:0] CtrlReset = DATA_WIDTH'(CTRL_RESET);
  localparam logic [DATA_WIDTH-1:0] Reg1Reset = DATA_WIDTH'(REG1_RESET);
  localparam logic [DATA_WIDTH-1:0] Reg2Reset = DATA_WIDTH'(REG2_RESET);
  localparam logic [DATA_WIDTH-1:0] Reg3Reset = DATA_WIDTH'(REG3_RESET);
  localparam logic [DATA_WIDTH-1:0] IdValue   = DATA_WIDTH'(ID_VALUE);

  reg_sel_e sel;

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
  logic [DATA_WIDTH-1:0] reg2_q, reg2_d;
  logic [DATA_WIDTH-1:0] reg3_q, reg3_d;

  // Full-width compare, so misaligned or aliased addresses fall through to SelNone.
  always_comb begin
    sel = SelNone;
    if (addr == AddrCtrl) begin
      sel = SelCtrl;
    end else if (addr == AddrReg1) begin
      sel = SelReg1;
    end else if (addr == AddrReg2) begin
      sel = SelReg2;
    end else if (addr == AddrReg3) begin
      sel = SelReg3;
    end else if (addr == AddrId) begin
      sel = SelId;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    reg1_d = reg1_q;
    reg2_d = reg2_q;
    reg3_d = reg3_q;
    if (wr_en) begin
      case (sel)
        SelCtrl: ctrl_d = wdata & CtrlMask;
        SelReg1: reg1_d = wdata;
        SelReg2: reg2_d = wdata;
        SelReg3: reg3_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctrl_q <= CtrlReset;
      reg1_q <= Reg1Reset;
      reg2_q <= Reg2Reset;
      reg3_q <= Reg3Reset;
    end else begin
      ctrl_q <= ctrl_d;
      reg1_q <= reg1_d;
      reg2_q <= reg2_d;
      reg3_q <= reg3_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SelCtrl: rdata = ctrl_q;
      SelReg1: rdata = reg1_q;
      SelReg2: rdata = reg2_q;
      SelReg3: rdata = reg3_q;
      SelId:   rdata = IdValue;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/modport_apb_slave.sv
// Zero-wait-state APB3 slave: phase decode and registered prdata in front of the register file.
// prdata is captured in the read setup phase so it is stable for the whole access phase.
module modport_apb_slave
  import modport_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata
);

  logic                  wr_access;
  logic                  rd_setup;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  assign wr_access = psel & penable & pwrite;
  assign rd_setup  = psel & ~penable & ~pwrite;

  modport_apb_regfile #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .pclk   (pclk),
    .presetn(presetn),
    .wr_en  (wr_access),
    .addr   (paddr),
    .wdata  (pwdata),
    .rdata  (rf_rdata)
  );

  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      prdata_d = rf_rdata;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else begin
      prdata_q <= prdata_d;
    end
  end

  assign prdata = prdata_q;

endmodule

// File: tb/tb_modport_apb_slave.sv
// Directed bench for modport_apb_slave: reset values, RW/RO behaviour, decode holes,
// back-to-back transfers and reset during a write access phase.
module tb_modport_apb_slave;

  logic        pclk;
  logic        presetn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  int n_total;
  int n_bad;

  modport_apb_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Tasks start and end on a negedge; calling one straight after another gives no idle cycle.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [31:0] held;
    n_total = 0;
    n_bad   = 0;
    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;

    // 1. reset values
    repeat (3) @(negedge pclk);
    check_eq("reset_prdata", prdata, 32'h0);
    presetn = 1'b1;
    idle();
    read_check("rst_ctrl", 32'h00, 32'h0000_0000);
    read_check("rst_reg1", 32'h04, 32'h0000_0000);
    read_check("rst_reg2", 32'h08, 32'h1234_5678);
    read_check("rst_reg3", 32'h0C, 32'hFFFF_0000);
    read_check("rst_id",   32'h10, 32'h0A9B_0001);

    // 2. RW registers and CTRL mask
    idle();
    apb_write(32'h04, 32'hDEAD_BEEF);
    idle();
    read_check("reg1_rw", 32'h04, 32'hDEAD_BEEF);
    apb_write(32'h00, 32'hFFFF_FFFF);
    idle();
    read_check("ctrl_mask", 32'h00, 32'h0000_00FF);

    // prdata must not move during a write
    held = prdata;
    apb_write(32'h0C, 32'h0BAD_F00D);
    check_eq("prdata_hold_wr", prdata, held);
    apb_write(32'h0C, 32'hFFFF_0000);
    idle();

    // 3. RO ID and unmapped address
    apb_write(32'h10, 32'h5555_5555);
    idle();
    read_check("id_ro", 32'h10, 32'h0A9B_0001);
    apb_write(32'h40, 32'h1111_2222);
    idle();
    read_check("unmapped_rd", 32'h40, 32'h0);
    read_check("keep_ctrl", 32'h00, 32'h0000_00FF);
    read_check("keep_reg1", 32'h04, 32'hDEAD_BEEF);
    read_check("keep_reg2", 32'h08, 32'h1234_5678);
    read_check("keep_reg3", 32'h0C, 32'hFFFF_0000);

    // penable without psel must be ignored
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0;
    @(negedge pclk);
    idle();
    read_check("no_psel_wr", 32'h04, 32'hDEAD_BEEF);

    // 4. back-to-back write then read, plus misaligned read
    apb_write(32'h08, 32'hA5A5_A5A5);
    read_check("b2b_reg2", 32'h08, 32'hA5A5_A5A5);
    read_check("misaligned", 32'h06, 32'h0);
    read_check("unmapped_14", 32'h14, 32'h0);

    // 5. reset during the access phase of a REG3 write
    idle();
    read_check("pre_rst_reg1", 32'h04, 32'hDEAD_BEEF);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h0000_0001;
    @(negedge pclk);
    penable = 1'b1;
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    psel = 1'b0; penable = 1'b0;
    check_eq("midrst_prdata", prdata, 32'h0);
    idle();
    read_check("midrst_reg3", 32'h0C, 32'hFFFF_0000);
    read_check("midrst_reg1", 32'h04, 32'h0000_0000);
    read_check("midrst_reg2", 32'h08, 32'h1234_5678);

    idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
